// File: rtl/minesweeper_pkg.sv
// Shared minesweeper definitions: tile codes, grid defaults, register-29 field
// layout and the tile-write queue entry.
package minesweeper_pkg;

    localparam logic [3:0] TILE_MINE   = 4'd9;
    localparam logic [3:0] TILE_FLAG   = 4'd10;
    localparam logic [3:0] TILE_HIDDEN = 4'd11;

    localparam int DEFAULT_GRID_COLS = 16;
    localparam int DEFAULT_GRID_ROWS = 16;

    // blockID register layout
    localparam int BID_TOGGLE_BIT = 31;
    localparam int BID_CODE_LSB   = 8;
    localparam int BID_ROW_LSB    = 4;
    localparam int BID_COL_LSB    = 0;
    localparam int BID_FIELD_W    = 4;

    typedef struct packed {
        logic [7:0] addr;
        logic [3:0] code;
    } tile_entry_t;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_REQ  = 1'b1
    } wr_state_e;

endpackage

// File: rtl/blockid_fifo.sv
// Synchronous FIFO of tile-write entries; pointers carry one extra wrap bit so
// full and empty are distinguished without a separate count.
module blockid_fifo
    import minesweeper_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        push,
    input  logic        pop,
    input  tile_entry_t wrData,
    output tile_entry_t rdData,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;
    tile_entry_t mem [DEPTH];

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push) mem[wrPtr[AW-1:0]] <= wrData;
    end

    assign rdData = mem[rdPtr[AW-1:0]];
    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

endmodule

// File: rtl/blockid_tile_writer.sv
// Detects new tile commands posted to register 29, queues them and writes each
// to tile memory over req/ack. Optional drop counter: BLOCKID_DROP_CNT_EN.
module blockid_tile_writer
    import minesweeper_pkg::*;
#(
    parameter int GRID_COLS  = DEFAULT_GRID_COLS,
    parameter int GRID_ROWS  = DEFAULT_GRID_ROWS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic [31:0] blockID_data,
    output logic        tile_req,
    output logic [7:0]  tile_addr,
    output logic [3:0]  tile_code,
    input  logic        tile_ack,
    output logic        fifo_full,
    output logic        range_err,
`ifdef BLOCKID_DROP_CNT_EN
    output logic [7:0]  drop_count,
`endif
    output wr_state_e   dbgState
);

    logic                   lastToggle;
    logic                   cmdToggle;
    logic [BID_FIELD_W-1:0] cmdCode;
    logic [BID_FIELD_W-1:0] cmdRow;
    logic [BID_FIELD_W-1:0] cmdCol;
    logic                   newCmd;
    logic                   inRange;
    logic [7:0]             cmdAddr;
    logic                   pushFifo;
    logic                   popFifo;
    logic                   fifoFull;
    logic                   fifoEmpty;
    tile_entry_t            wrEntry;
    tile_entry_t            headEntry;
    wr_state_e              state;
    logic                   unusedBits;

    assign cmdToggle  = blockID_data[BID_TOGGLE_BIT];
    assign cmdCode    = blockID_data[BID_CODE_LSB +: BID_FIELD_W];
    assign cmdRow     = blockID_data[BID_ROW_LSB +: BID_FIELD_W];
    assign cmdCol     = blockID_data[BID_COL_LSB +: BID_FIELD_W];
    assign unusedBits = ^blockID_data[30:12];

    assign newCmd  = (cmdToggle != lastToggle);
    assign inRange = (int'(cmdRow) < GRID_ROWS) && (int'(cmdCol) < GRID_COLS);
    assign cmdAddr = 8'(int'(cmdRow) * GRID_COLS + int'(cmdCol));
    assign wrEntry = '{addr: cmdAddr, code: cmdCode};

    // A full queue still accepts a command on the edge that also pops the head.
    assign popFifo  = (state == WR_IDLE) && !fifoEmpty;
    assign pushFifo = newCmd && inRange && (!fifoFull || popFifo);

    blockid_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .ctrl_reset(ctrl_reset),
        .push      (pushFifo),
        .pop       (popFifo),
        .wrData    (wrEntry),
        .rdData    (headEntry),
        .full      (fifoFull),
        .empty     (fifoEmpty)
    );

    // Toggle is sampled every cycle, so dropped and rejected commands are never retried.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            lastToggle <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            lastToggle <= cmdToggle;
            if (newCmd && !inRange) range_err <= 1'b1;
        end
    end

    // Handshake: tile_req rises with addr/code loaded and all three hold until
    // tile_ack is seen high at a posedge; req then stays low for at least one
    // cycle before the next write. tile_ack outside a request is ignored.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state     <= WR_IDLE;
            tile_req  <= 1'b0;
            tile_addr <= '0;
            tile_code <= '0;
        end else begin
            case (state)
                WR_IDLE: begin
                    if (!fifoEmpty) begin
                        tile_addr <= headEntry.addr;
                        tile_code <= headEntry.code;
                        tile_req  <= 1'b1;
                        state     <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (tile_ack) begin
                        tile_req <= 1'b0;
                        state    <= WR_IDLE;
                    end
                end
                default: state <= WR_IDLE;
            endcase
        end
    end

`ifdef BLOCKID_DROP_CNT_EN
    logic dropCmd;
    assign dropCmd = newCmd && inRange && fifoFull && !popFifo;

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            drop_count <= '0;
        end else if (dropCmd && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

    assign fifo_full = fifoFull;
    assign dbgState  = state;

endmodule

// File: tb/tb_blockid_tile_writer.sv
// Self-checking bench for blockid_tile_writer: directed scenarios plus random
// posts scored against an expected-transfer queue.
module tb_blockid_tile_writer;
    import minesweeper_pkg::*;

    localparam int COLS  = 16;
    localparam int ROWS  = 10;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic [31:0] blockID_data;
    logic        tile_req;
    logic [7:0]  tile_addr;
    logic [3:0]  tile_code;
    logic        tile_ack;
    logic        fifo_full;
    logic        range_err;
    wr_state_e   dbgState;
`ifdef BLOCKID_DROP_CNT_EN
    logic [7:0]  drop_count;
`endif

    int          errors = 0;
    int          checks = 0;
    int          xferCount = 0;
    int          expDrops = 0;
    bit          expRangeErr = 1'b0;
    logic        curToggle = 1'b0;
    logic [11:0] exp_q[$];

    blockid_tile_writer #(
        .GRID_COLS (COLS),
        .GRID_ROWS (ROWS),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock       (clock),
        .ctrl_reset  (ctrl_reset),
        .blockID_data(blockID_data),
        .tile_req    (tile_req),
        .tile_addr   (tile_addr),
        .tile_code   (tile_code),
        .tile_ack    (tile_ack),
        .fifo_full   (fifo_full),
        .range_err   (range_err),
`ifdef BLOCKID_DROP_CNT_EN
        .drop_count  (drop_count),
`endif
        .dbgState    (dbgState)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [11:0] model_entry(input int row, input int col, input int code);
        return 12'((row * COLS + col) * 16 + code);
    endfunction

    // Drive one command with the toggle flipped; record its expected fate.
    task automatic post_cmd(input int row, input int col, input int code, input bit willDrop);
        curToggle = ~curToggle;
        blockID_data = {curToggle, 19'($urandom), 4'(code), 4'(row), 4'(col)};
        if (row >= ROWS || col >= COLS) expRangeErr = 1'b1;
        else if (willDrop) expDrops = (expDrops < 255) ? expDrops + 1 : 255;
        else exp_q.push_back(model_entry(row, col, code));
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !tile_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // Inputs change on negedge; 1ns later req/ack show whether the next posedge completes a write.
    always @(negedge clock) begin
        #1;
        if (ctrl_reset === 1'b0 && tile_req === 1'b1 && tile_ack === 1'b1) begin
            logic [11:0] exp;
            xferCount++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected got addr=%0d code=%0d, expected no transfer", tile_addr, tile_code);
            end else begin
                exp = exp_q.pop_front();
                if ({tile_addr, tile_code} !== exp) begin
                    errors++;
                    $display("FAIL xfer_data got addr=%0d code=%0d, expected addr=%0d code=%0d",
                             tile_addr, tile_code, exp[11:4], exp[3:0]);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        ctrl_reset   = 1'b1;
        blockID_data = '0;
        tile_ack     = 1'b0;
        curToggle    = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (tile_req !== 1'b0) begin errors++; $display("FAIL reset_tile_req got=%b exp=0", tile_req); end
        checks++;
        if (tile_addr !== 8'd0) begin errors++; $display("FAIL reset_tile_addr got=%0d exp=0", tile_addr); end
        checks++;
        if (tile_code !== 4'd0) begin errors++; $display("FAIL reset_tile_code got=%0d exp=0", tile_code); end
        checks++;
        if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full got=%b exp=0", fifo_full); end
        checks++;
        if (range_err !== 1'b0) begin errors++; $display("FAIL reset_range_err got=%b exp=0", range_err); end
        checks++;
        if (dbgState !== WR_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbgState, WR_IDLE); end
`ifdef BLOCKID_DROP_CNT_EN
        checks++;
        if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
`endif
        ctrl_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (tile_req !== 1'b0) begin errors++; $display("FAIL idle_no_req cycle=%0d got=%b exp=0", i, tile_req); end
        end
    endtask

    task automatic test_first_post();
        @(negedge clock);
        post_cmd(2, 3, TILE_MINE, 1'b0);
        @(negedge clock);
        checks++;
        if (tile_req !== 1'b0) begin errors++; $display("FAIL latency_req_early got=%b exp=0", tile_req); end
        @(negedge clock);
        checks++;
        if (tile_req !== 1'b1) begin errors++; $display("FAIL latency_req got=%b exp=1", tile_req); end
        checks++;
        if (tile_addr !== 8'd35) begin errors++; $display("FAIL first_addr got=%0d exp=35", tile_addr); end
        checks++;
        if (tile_code !== 4'd9) begin errors++; $display("FAIL first_code got=%0d exp=9", tile_code); end
        checks++;
        if (dbgState !== WR_REQ) begin errors++; $display("FAIL first_state got=%0d exp=%0d", dbgState, WR_REQ); end
        tile_ack = 1'b1;
        @(negedge clock);
        checks++;
        if (tile_req !== 1'b0) begin errors++; $display("FAIL ack_drop_req got=%b exp=0", tile_req); end
    endtask

    task automatic test_repeat_cmd();
        int start;
        bit ok;
        start = xferCount;
        @(negedge clock);
        post_cmd(2, 3, TILE_MINE, 1'b0);
        drain(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL repeat_drain got=timeout exp=drained"); end
        checks++;
        if (xferCount - start !== 1) begin errors++; $display("FAIL repeat_count got=%0d exp=1", xferCount - start); end
        start = xferCount;
        @(negedge clock);
        blockID_data[11:8] = 4'd5;
        blockID_data[7:0]  = 8'h11;
        repeat (10) @(negedge clock);
        checks++;
        if (xferCount !== start) begin errors++; $display("FAIL no_toggle_no_xfer got=%0d exp=%0d", xferCount, start); end
    endtask

    task automatic test_backpressure();
        int start;
        bit ok;
        start = xferCount;
        @(negedge clock);
        tile_ack = 1'b0;
        // With ack held, one command sits in the output registers and DEPTH more queue up.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            post_cmd(i, 15 - i, i + 3, (i >= DEPTH + 1));
        end
        @(negedge clock);
        checks++;
        if (fifo_full !== 1'b1) begin errors++; $display("FAIL bp_fifo_full got=%b exp=1", fifo_full); end
        checks++;
        if (tile_req !== 1'b1 || tile_addr !== 8'd15) begin
            errors++; $display("FAIL bp_hold got req=%b addr=%0d exp req=1 addr=15", tile_req, tile_addr);
        end
`ifdef BLOCKID_DROP_CNT_EN
        checks++;
        if (drop_count !== 8'(expDrops)) begin errors++; $display("FAIL bp_drop_count got=%0d exp=%0d", drop_count, expDrops); end
`endif
        tile_ack = 1'b1;
        drain(60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_drain got=timeout exp=drained"); end
        checks++;
        if (xferCount - start !== 5) begin errors++; $display("FAIL bp_count got=%0d exp=5", xferCount - start); end
        checks++;
        if (fifo_full !== 1'b0) begin errors++; $display("FAIL bp_full_clear got=%b exp=0", fifo_full); end
    endtask

    task automatic test_range_err();
        int start;
        bit ok;
        checks++;
        if (range_err !== 1'b0) begin errors++; $display("FAIL range_pre got=%b exp=0", range_err); end
        start = xferCount;
        @(negedge clock);
        post_cmd(12, 3, TILE_FLAG, 1'b0);
        repeat (20) @(negedge clock);
        checks++;
        if (range_err !== 1'b1) begin errors++; $display("FAIL range_sticky got=%b exp=1", range_err); end
        checks++;
        if (xferCount !== start) begin errors++; $display("FAIL range_no_xfer got=%0d exp=%0d", xferCount, start); end
        @(negedge clock);
        post_cmd(9, 15, TILE_HIDDEN, 1'b0);
        drain(20, ok);
        checks++;
        if (!ok || xferCount !== start + 1) begin
            errors++; $display("FAIL range_legal_after got ok=%b count=%0d exp ok=1 count=%0d", ok, xferCount, start + 1);
        end
    endtask

    task automatic test_reset_mid();
        int start;
        bit ok;
        @(negedge clock);
        tile_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            post_cmd(1, i, i, 1'b0);
        end
        @(negedge clock);
        checks++;
        if (dbgState !== WR_REQ || tile_req !== 1'b1) begin
            errors++; $display("FAIL mid_pre got state=%0d req=%b exp state=%0d req=1", dbgState, tile_req, WR_REQ);
        end
        #3;
        ctrl_reset   = 1'b1;
        blockID_data = '0;
        curToggle    = 1'b0;
        exp_q.delete();
        expDrops     = 0;
        expRangeErr  = 1'b0;
        #1;
        checks++;
        if (tile_req !== 1'b0) begin errors++; $display("FAIL mid_async_req got=%b exp=0", tile_req); end
        @(negedge clock);
        ctrl_reset = 1'b0;
        tile_ack   = 1'b1;
        start      = xferCount;
        repeat (10) @(negedge clock);
        checks++;
        if (xferCount !== start) begin errors++; $display("FAIL mid_no_xfer got=%0d exp=%0d", xferCount, start); end
        checks++;
        if (fifo_full !== 1'b0 || range_err !== 1'b0) begin
            errors++; $display("FAIL mid_flags got full=%b err=%b exp full=0 err=0", fifo_full, range_err);
        end
        @(negedge clock);
        post_cmd(4, 4, TILE_HIDDEN, 1'b0);
        drain(20, ok);
        checks++;
        if (!ok || xferCount !== start + 1) begin
            errors++; $display("FAIL mid_post_after got ok=%b count=%0d exp ok=1 count=%0d", ok, xferCount, start + 1);
        end
    endtask

    task automatic test_push_pop_full();
        int start;
        bit ok;
        start = xferCount;
        @(negedge clock);
        tile_ack = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            @(negedge clock);
            post_cmd(i, i + 2, 15 - i, 1'b0);
        end
        @(negedge clock);
        checks++;
        if (fifo_full !== 1'b1) begin errors++; $display("FAIL ppf_full got=%b exp=1", fifo_full); end
        tile_ack = 1'b1;
        @(negedge clock);
        checks++;
        if (tile_req !== 1'b0) begin errors++; $display("FAIL ppf_req_gap got=%b exp=0", tile_req); end
        // The new command lands on the same edge that pops the next head from the full queue.
        post_cmd(7, 7, TILE_FLAG, 1'b0);
        tile_ack = 1'b0;
        @(negedge clock);
        checks++;
        if (fifo_full !== 1'b1 || tile_req !== 1'b1) begin
            errors++; $display("FAIL ppf_after got full=%b req=%b exp full=1 req=1", fifo_full, tile_req);
        end
`ifdef BLOCKID_DROP_CNT_EN
        checks++;
        if (drop_count !== 8'(expDrops)) begin errors++; $display("FAIL ppf_drop_count got=%0d exp=%0d", drop_count, expDrops); end
`endif
        tile_ack = 1'b1;
        drain(60, ok);
        checks++;
        if (!ok || xferCount - start !== 6) begin
            errors++; $display("FAIL ppf_count got ok=%b count=%0d exp ok=1 count=6", ok, xferCount - start);
        end
    endtask

    task automatic test_random();
        int start;
        int legal;
        int row;
        bit ok;
        start = xferCount;
        legal = 0;
        tile_ack = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            repeat ($urandom_range(1, 3)) @(negedge clock);
            if ($urandom_range(0, 3) == 0) begin
                blockID_data = {curToggle, 31'($urandom)};
            end else begin
                row = $urandom_range(0, 15);
                if (row < ROWS) legal++;
                post_cmd(row, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0);
            end
        end
        drain(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rand_drain got=timeout exp=drained"); end
        checks++;
        if (xferCount - start !== legal) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", xferCount - start, legal); end
        checks++;
        if (range_err !== expRangeErr) begin errors++; $display("FAIL rand_range_err got=%b exp=%b", range_err, expRangeErr); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_first_post();
        test_repeat_cmd();
        test_backpressure();
        test_range_err();
        test_reset_mid();
        test_push_pop_full();
        test_random();
        repeat (3) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue got=%0d pending exp=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
